// File: rtl/demux_pkg.sv
// Shared constants, slot state type and a popcount helper for the buffered 1-to-8 demux.
package demux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int NCH       = 8;
    localparam int SEL_W     = 3;
    localparam int OCC_W     = 4;

    localparam logic [SEL_W-1:0] CH0 = 3'd0;
    localparam logic [SEL_W-1:0] CH1 = 3'd1;
    localparam logic [SEL_W-1:0] CH2 = 3'd2;
    localparam logic [SEL_W-1:0] CH3 = 3'd3;
    localparam logic [SEL_W-1:0] CH4 = 3'd4;
    localparam logic [SEL_W-1:0] CH5 = 3'd5;
    localparam logic [SEL_W-1:0] CH6 = 3'd6;
    localparam logic [SEL_W-1:0] CH7 = 3'd7;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Number of set bits in a channel vector; result spans 0..NCH.
    function automatic logic [OCC_W-1:0] popcount_ch(input logic [NCH-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready handshake for a single demux channel.
//
// state      | meaning
// -----------+-----------------------------------------------
// SLOT_EMPTY | no undelivered byte; a write fills the slot
// SLOT_FULL  | byte waiting; drain without write empties it,
//            | write (with or without drain) replaces the byte
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state and data-capture logic; stale data is kept on drain.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: if (wr_en) state_d = SLOT_FULL;
            SLOT_FULL:  if (rd_ready && !wr_en) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
        if (wr_en) data_d = wr_data;
    end

    // State and holding register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data  = data_q;
    assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux1to8_buf.sv
// Buffered 1-to-8 demux: steers a byte to one of eight holding slots so a stalled
// consumer only blocks writes aimed at its own channel.
module demux1to8_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [OCC_W-1:0] occupancy
);

    logic [NCH-1:0]   wr_en;
    logic [NCH-1:0]   valid_nxt;
    logic [WIDTH-1:0] slot_data [NCH];
    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    // Only the addressed channel decides readiness; in_valid is deliberately not involved.
    assign in_ready = !out_valid[sel] || out_ready[sel];

    // Decode the accepted write to a one-hot slot enable and predict next valid vector.
    always_comb begin
        wr_en = '0;
        for (int k = 0; k < NCH; k++) begin
            wr_en[k] = in_valid && in_ready && (sel == SEL_W'(k));
        end
        valid_nxt   = wr_en | (out_valid & ~out_ready);
        occupancy_d = popcount_ch(valid_nxt);
    end

    // Occupancy tracks the slot valids one cycle ahead so it lines up with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) occupancy_q <= '0;
        else        occupancy_q <= occupancy_d;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[g]),
            .wr_data  (in_data),
            .rd_ready (out_ready[g]),
            .data     (slot_data[g]),
            .valid    (out_valid[g])
        );
    end

    assign out1      = slot_data[CH0];
    assign out2      = slot_data[CH1];
    assign out3      = slot_data[CH2];
    assign out4      = slot_data[CH3];
    assign out5      = slot_data[CH4];
    assign out6      = slot_data[CH5];
    assign out7      = slot_data[CH6];
    assign out8      = slot_data[CH7];
    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_demux1to8_buf.sv
// Self-checking bench for demux1to8_buf: directed scenarios plus random traffic
// against a channel-array reference model.
module tb_demux1to8_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic [2:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out1, out2, out3, out4, out5, out6, out7, out8;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [3:0] occupancy;
    logic [7:0] outs [8];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one byte and one full flag per channel.
    logic [7:0] m_data [8];
    bit         m_full [8];

    always #10 clk = ~clk;

    demux1to8_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out8      (out8),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    assign outs[0] = out1;
    assign outs[1] = out2;
    assign outs[2] = out3;
    assign outs[3] = out4;
    assign outs[4] = out5;
    assign outs[5] = out6;
    assign outs[6] = out7;
    assign outs[7] = out8;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int k = 0; k < 8; k++) if (m_full[k]) c++;
        return c;
    endfunction

    function automatic logic [7:0] m_valid_vec();
        logic [7:0] v = '0;
        for (int k = 0; k < 8; k++) v[k] = m_full[k];
        return v;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 8; k++) begin
            m_full[k] = 0;
            m_data[k] = 8'h00;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".out_valid"}, out_valid, m_valid_vec());
        chk({tag, ".occupancy"}, occupancy, m_count());
        for (int k = 0; k < 8; k++)
            if (m_full[k]) chk($sformatf("%s.out%0d", tag, k + 1), outs[k], m_data[k]);
    endtask

    // One clock cycle: drive, check at negedge, update model at posedge.
    // Entered and left just after a rising edge.
    task automatic cyc(input bit v, input logic [2:0] s, input logic [7:0] d,
                       input logic [7:0] rdy, input string tag);
        bit rdy_exp;
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        rdy_exp = !m_full[s] || rdy[s];
        check_state(tag);
        chk({tag, ".in_ready"}, in_ready, rdy_exp);
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (v && rdy_exp && s == 3'(k)) begin
                m_data[k] = d;
                m_full[k] = 1;
            end else if (rdy[k]) begin
                m_full[k] = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset_async(input string tag);
        rst_n = 1'b0;
        #1;
        m_clear();
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".occupancy"}, occupancy, 0);
        for (int k = 0; k < 8; k++) chk($sformatf("%s.out%0d", tag, k + 1), outs[k], 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int occ_before;
        rst_n = 1'b0; in_valid = 0; sel = 0; in_data = 0; out_ready = 0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.occupancy", occupancy, 0);
        rst_n = 1'b1;

        // Basic steer
        cyc(1, 3'd5, 8'h3C, 8'h00, "steer");
        cyc(0, 3'd0, 8'h00, 8'h00, "steer_chk");
        chk("steer.out6", out6, 8'h3C);
        chk("steer.valid", out_valid, 8'b0010_0000);
        chk("steer.occ", occupancy, 1);
        cyc(0, 3'd0, 8'h00, 8'h20, "steer_drain");

        // Backpressure on channel 2
        cyc(1, 3'd2, 8'h22, 8'h00, "bp_fill");
        for (int i = 0; i < 3; i++) cyc(1, 3'd2, 8'h11, 8'h00, "bp_stall");
        cyc(1, 3'd2, 8'h11, 8'h04, "bp_accept");
        cyc(0, 3'd0, 8'h00, 8'h00, "bp_after");
        chk("bp.out3", out3, 8'h11);
        chk("bp.valid2", out_valid[2], 1);

        // Pass-through on channel 7
        cyc(1, 3'd7, 8'hAA, 8'h00, "pt_fill");
        occ_before = m_count();
        cyc(1, 3'd7, 8'h55, 8'h80, "pt_same");
        cyc(0, 3'd0, 8'h00, 8'h00, "pt_after");
        chk("pt.out8", out8, 8'h55);
        chk("pt.valid7", out_valid[7], 1);
        chk("pt.occ", occupancy, occ_before);

        // Stall isolation: channel 0 blocked, channel 4 still writable
        cyc(0, 3'd0, 8'h00, 8'hFF, "iso_clear");
        cyc(1, 3'd0, 8'h77, 8'h00, "iso_fill0");
        cyc(1, 3'd4, 8'h9E, 8'h00, "iso_wr4");
        cyc(0, 3'd0, 8'h00, 8'h00, "iso_after");
        chk("iso.out5", out5, 8'h9E);
        chk("iso.out1", out1, 8'h77);

        // Fill all channels
        cyc(0, 3'd0, 8'h00, 8'hFF, "fill_clear");
        for (int k = 0; k < 8; k++) cyc(1, 3'(k), 8'(k), 8'h00, "fill");
        chk("fill.occ", occupancy, 8);
        for (int k = 0; k < 8; k++) chk($sformatf("fill.out%0d", k + 1), outs[k], k);
        in_valid = 0;
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            #1;
            chk($sformatf("fill.in_ready%0d", k), in_ready, 0);
        end
        cyc(0, 3'd0, 8'h00, 8'hFF, "fill_drain");
        chk("fill.occ_empty", occupancy, 0);

        // Async reset with out_valid = 8'hA5
        cyc(1, 3'd0, 8'hC0, 8'h00, "rst_fill");
        cyc(1, 3'd2, 8'hC2, 8'h00, "rst_fill");
        cyc(1, 3'd5, 8'hC5, 8'h00, "rst_fill");
        cyc(1, 3'd7, 8'hC7, 8'h00, "rst_fill");
        chk("rst.pre_valid", out_valid, 8'hA5);
        do_reset_async("rst_mid");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] rdy;
            rdy = 8'($urandom) & 8'($urandom);
            if (i == 200) do_reset_async("rst_rand");
            cyc(($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), rdy, "rand");
        end
        cyc(0, 3'd0, 8'h00, 8'h00, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demux1to8_buf.md
Name: demux1to8_buf

Overview:
- Buffered 1-to-8 demultiplexer: the write-side counterpart of the processor's 8-to-1 read mux.
- Steers one input byte to one of eight destination channels, selected by a 3-bit sel.
- Each channel has a one-entry holding register and a valid/ready handshake.
- Sits between the datapath result bus and eight independent consumers (register ports, I/O latches) so that a stalled consumer blocks only writes aimed at it.

Parameters:
- WIDTH, 8, data width of the input and of every output channel
- NCH, 8, number of channels; fixed at 8 (sel is 3 bits) and not to be overridden

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  byte to deliver
- sel  input  3  destination channel; 3'd0 selects out1 ... 3'd7 selects out8
- in_valid  input  1  upstream offers in_data/sel this cycle
- in_ready  output  1  block accepts this cycle (combinational)
- out1..out8  output  WIDTH each  channel holding-register contents
- out_valid  output  8  bit k-1 set when outk holds undelivered data
- out_ready  input  8  bit k-1: consumer k takes outk this cycle
- occupancy  output  4  number of channels currently valid, 0..8

Behaviour:
- Reset, asynchronous, active-low:
  - out_valid=8'h00, out1..out8=0, occupancy=0.
  - Holds while rst_n=0; release is synchronous to the next clk edge.
  - Asserting reset mid-transfer discards all held data with no delivery.
- in_ready = !out_valid[sel] | out_ready[sel]. Combinational from sel and the out_ready bit of the addressed channel only; no dependence on in_valid.
- Accept = in_valid & in_ready. On accept at edge t:
  - out{sel+1} <= in_data
  - out_valid[sel] <= 1, visible at t+1 (latency 1 cycle)
- Drain of channel k = out_valid[k] & out_ready[k]. On drain with no accept to k: out_valid[k] <= 0; data is kept but is don't-care.
- Accept and drain on the same channel in the same cycle: out_valid stays 1 and the data is replaced by the new byte. This gives one transfer per cycle sustained throughput per channel.
- Accept to channel j and drains on other channels in the same cycle are all performed independently.
- out_ready on a channel that is not valid is ignored.
- Stall (in_valid=1, in_ready=0): nothing is written. Upstream must hold in_data and sel stable until accept. A sel change while stalled is a protocol violation, but the block stays consistent because in_ready is re-evaluated against the new sel.
- in_valid=0: no write, regardless of sel.
- Outputs are registered, with no combinational path from in_data to outk.
- occupancy is a registered popcount of next-state out_valid:
  - +1 on accept to an empty or non-draining channel
  - -1 per drain without a same-channel accept
  - Net change per cycle ranges from -8 to +1.
  - Saturation is impossible by construction; range is 0..8.
- Per-channel state machine, 2 states:
  - EMPTY: accept -> FULL
  - FULL: drain & !accept -> EMPTY; otherwise stays FULL (data replaced on accept & drain)

Decomposition:
- Shared package/header demux_pkg:
  - WIDTH default
  - NCH=8
  - SEL_W=3
  - channel-index constants CH0..CH7
- Sub-module demux_slot: one channel holding register. Ports clk, rst_n, wr_en, wr_data, rd_ready, data, valid. Instantiated 8 times.
- Top-level logic: the sel decode, the in_ready mux and the occupancy counter.

Test Plan:
- Reset: rst_n=0 mid-run with out_valid=8'hA5 -> out_valid=0, occupancy=0, out1..out8=0 immediately, without waiting for a clock edge.
- Basic steer: in_data=8'h3C, sel=3'd5, in_valid=1, out_ready=0 -> next cycle out6=8'h3C, out_valid=8'b0010_0000, occupancy=1, all other channels unchanged.
- Backpressure: channel 2 full and out_ready[2]=0, offer sel=3'd2 data 8'h11 -> in_ready=0. Held for 3 cycles, then out_ready[2]=1 -> accept that cycle; out3=8'h11 next cycle with valid still 1.
- Pass-through: channel 7 full (out8=8'hAA), out_ready[7]=1, accept 8'h55 to sel=3'd7 in the same cycle -> out8=8'h55, out_valid[7]=1, occupancy unchanged.
- Fill all: write 8'h00..8'h07 to sel 0..7 on consecutive cycles with out_ready=0 -> occupancy=8, outk=k-1, and in_ready=0 for every sel. Then out_ready=8'hFF for one cycle -> occupancy=0.
- Stall isolation: channel 0 full and blocked; sel=3'd4 write 8'h9E -> accepted immediately and out5=8'h9E, while out1 is preserved.
